bp_me_cache_dma_responder: RTL



---
 rtl/bp_me_cache_dma_responder_pkg.sv | 5 +
 rtl/bp_me_cache_dma_responder_mem.sv | 16 +
 rtl/bp_me_cache_dma_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bp_me_cache_dma_responder_pkg.sv
// bp_me_cache_dma_responder_pkg: shared types for the bsg_cache DMA responder
package bp_me_cache_dma_responder_pkg;
   typedef enum logic [1:0] {e_idle, e_wait, e_read, e_write} bp_me_dma_resp_state_e;
   localparam int fifo_els_lp = 2;
endpackage

// File: rtl/bp_me_cache_dma_responder_mem.sv
// bp_me_cache_dma_responder_mem: single-port synchronous beat RAM, read data valid the cycle after v_i
module bp_me_cache_dma_responder_mem
 #(parameter int width_p = 64
   , parameter int els_p = 4096
   , localparam int addr_w_lp = $clog2(els_p))
  (input logic clk_i
   , input logic v_i
   , input logic w_i
   , input logic [addr_w_lp-1:0] addr_i
   , input logic [width_p-1:0] data_i
   , output logic [width_p-1:0] data_o);
   logic [width_p-1:0] mem_r [els_p];
   always_ff @(posedge clk_i)
      if (v_i && w_i) mem_r[addr_i] <= data_i;
      else if (v_i) data_o <= mem_r[addr_i];
endmodule

// File: rtl/bp_me_cache_dma_responder.sv
// bp_me_cache_dma_responder: bsg_cache DMA target; fills and absorbs whole blocks from a local beat RAM
module bp_me_cache_dma_responder
   import bp_me_cache_dma_responder_pkg::*;
 #(parameter int daddr_width_p = 28
   , parameter int l2_fill_width_p = 64
   , parameter int l2_block_width_p = 512
   , parameter int mem_els_p = 4096
   , parameter int read_latency_p = 4
   , localparam int dma_pkt_width_lp = daddr_width_p + 1)
  (input logic clk_i
   , input logic reset_n_i
   , input logic [dma_pkt_width_lp-1:0] dma_pkt_i
   , input logic dma_pkt_v_i
   , output logic dma_pkt_ready_and_o
   , output logic [l2_fill_width_p-1:0] dma_data_o
   , output logic dma_data_v_o
   , input logic dma_data_ready_and_i
   , input logic [l2_fill_width_p-1:0] dma_data_i
   , input logic dma_data_v_i
   , output logic dma_data_ready_and_o);
   localparam int beats_lp = l2_block_width_p / l2_fill_width_p;
   localparam int cnt_w_lp = beats_lp > 1 ? $clog2(beats_lp) : 1;
   localparam int idx_w_lp = $clog2(mem_els_p);
   localparam int off_w_lp = $clog2(l2_fill_width_p / 8);
   localparam int lat_w_lp = read_latency_p > 1 ? $clog2(read_latency_p) : 1;
   localparam logic [lat_w_lp-1:0] lat_init_lp = lat_w_lp'(read_latency_p > 0 ? read_latency_p - 1 : 0);
   localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);
   typedef struct packed {
      logic write_not_read;
      logic [daddr_width_p-1:0] addr;
   } dma_pkt_s;
   dma_pkt_s pkt;
   bp_me_dma_resp_state_e state_r;
   logic [idx_w_lp-1:0] base_r, new_base, ram_addr;
   logic [cnt_w_lp-1:0] rd_cnt_r, wr_cnt_r;
   logic [lat_w_lp-1:0] wait_cnt_r;
   logic [1:0] fifo_cnt_r;
   logic [l2_fill_width_p-1:0] fifo_mem_r [fifo_els_lp];
   logic [l2_fill_width_p-1:0] ram_data;
   logic fifo_rptr_r, fifo_wptr_r, rd_done_r, inflight_r, pkt_ready_r, data_ready_r;
   logic pkt_accept, pop, issue, wr_beat, read_exit, unused_addr;
   assign pkt = dma_pkt_i;
   assign unused_addr = ^pkt.addr;
   assign new_base = pkt.addr[idx_w_lp+off_w_lp-1:off_w_lp] & ~idx_w_lp'(beats_lp - 1);
   assign pkt_accept = pkt_ready_r & dma_pkt_v_i;
   assign dma_data_v_o = fifo_cnt_r != 2'd0;
   assign pop = dma_data_v_o & dma_data_ready_and_i;
   // Counting this cycle's pop lets a full pipeline keep issuing, giving one beat per cycle.
   assign issue = state_r == e_read && !rd_done_r
                  && (fifo_cnt_r + 2'(inflight_r) - 2'(pop)) < 2'(fifo_els_lp);
   assign wr_beat = data_ready_r & dma_data_v_i;
   assign read_exit = rd_done_r && !inflight_r && fifo_cnt_r == 2'(pop);
   assign ram_addr = wr_beat ? base_r + idx_w_lp'(wr_cnt_r) : base_r + idx_w_lp'(rd_cnt_r);
   assign dma_pkt_ready_and_o = pkt_ready_r;
   assign dma_data_ready_and_o = data_ready_r;
   assign dma_data_o = dma_data_v_o ? fifo_mem_r[fifo_rptr_r] : '0;
   bp_me_cache_dma_responder_mem #(.width_p(l2_fill_width_p), .els_p(mem_els_p)) mem (
      .clk_i(clk_i), .v_i(issue | wr_beat), .w_i(wr_beat), .addr_i(ram_addr)
      , .data_i(dma_data_i), .data_o(ram_data));
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state_r <= e_idle;
         base_r <= '0;
         rd_cnt_r <= '0;
         wr_cnt_r <= '0;
         wait_cnt_r <= '0;
         rd_done_r <= 1'b0;
         inflight_r <= 1'b0;
         pkt_ready_r <= 1'b0;
         data_ready_r <= 1'b0;
      end else begin
         inflight_r <= issue;
         if (issue) begin
            rd_cnt_r <= rd_cnt_r + 1'b1;
            rd_done_r <= rd_cnt_r == last_beat_lp;
         end
         if (wr_beat) wr_cnt_r <= wr_cnt_r + 1'b1;
         case (state_r)
            e_idle: begin
               pkt_ready_r <= !pkt_accept;
               if (pkt_accept) begin
                  base_r <= new_base;
                  rd_cnt_r <= '0;
                  wr_cnt_r <= '0;
                  rd_done_r <= 1'b0;
                  wait_cnt_r <= lat_init_lp;
                  data_ready_r <= pkt.write_not_read;
                  state_r <= pkt.write_not_read ? e_write : (read_latency_p == 0 ? e_read : e_wait);
               end
            end
            e_wait: begin
               wait_cnt_r <= wait_cnt_r - 1'b1;
               if (wait_cnt_r == '0) state_r <= e_read;
            end
            e_read: if (read_exit) begin
               state_r <= e_idle;
               pkt_ready_r <= 1'b1;
            end
            e_write: if (wr_beat && wr_cnt_r == last_beat_lp) begin
               state_r <= e_idle;
               data_ready_r <= 1'b0;
               pkt_ready_r <= 1'b1;
            end
            default: state_r <= e_idle;
         endcase
      end
   // RAM data arrives one cycle after issue, so inflight doubles as the FIFO push.
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         fifo_cnt_r <= '0;
         fifo_rptr_r <= 1'b0;
         fifo_wptr_r <= 1'b0;
      end else begin
         fifo_cnt_r <= fifo_cnt_r + 2'(inflight_r) - 2'(pop);
         fifo_wptr_r <= fifo_wptr_r ^ inflight_r;
         fifo_rptr_r <= fifo_rptr_r ^ pop;
      end
   always_ff @(posedge clk_i)
      if (inflight_r) fifo_mem_r[fifo_wptr_r] <= ram_data;
   param_check: assert property (@(posedge clk_i)
      (mem_els_p & (mem_els_p - 1)) == 0 && l2_block_width_p % l2_fill_width_p == 0 && beats_lp <= mem_els_p);
endmodule
